// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter driven by a valid/ready byte handshake, bit timing from a 16x tick divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
  parameter int CLKS_PER_TICK = 4,
  parameter int OVERSAMPLE    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy
);

  localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e          state_q, state_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      os_cnt_q, os_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic tick_wrap, bit_end, accept;

  assign ready_out = (state_q == IDLE) && ena;
  assign accept    = valid_in && ready_out;
  assign tick_wrap = (tick_cnt_q == TW'(CLKS_PER_TICK - 1));
  assign bit_end   = tick_wrap && (os_cnt_q == 4'(OVERSAMPLE - 1));
  assign tx        = tx_q;
  assign busy      = busy_q;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    tick_cnt_d = tick_cnt_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    // Divider free-runs for the whole frame; ena only gates acceptance.
    if (state_q != IDLE) begin
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);
      if (tick_wrap) os_cnt_d = os_cnt_q + 4'd1;
    end
    case (state_q)
      IDLE: if (accept) begin
        state_d    = START;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
        shift_d    = data_in;
        tick_cnt_d = '0;
        os_cnt_d   = '0;
        bit_idx_d  = '0;
`ifdef UART_TX_PARITY_EN
        par_d      = ^data_in;
`endif
      end
      START: if (bit_end) begin
        state_d   = DATA;
        tx_d      = shift_q[0];
        bit_idx_d = '0;
      end
      DATA: if (bit_end) begin
        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          tx_d      = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CLKS_PER_TICK=2 (32 clks per bit).
module tb_uart_transmitter;

  localparam int BIT = 32;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, tx, busy;

  int  n_cmp = 0;
  int  n_bad = 0;
  time last_acc_t = 0;

  typedef struct {
    logic [7:0] data;
    logic [0:9] frame;   // start, d0..d7, stop in line order
    logic       par;
  } vec_t;
  vec_t vecs [6];

  uart_transmitter #(.CLKS_PER_TICK(2), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input int vi, input int b);
`ifdef UART_TX_PARITY_EN
    if (b == 9)  return vecs[vi].par;
    if (b == 10) return 1'b1;
`endif
    return vecs[vi].frame[b];
  endfunction

  // Sends vecs[vi] and checks the frame mid-bit; optional valid pulse / ena drop at negedge k.
  task automatic send(input int vi, input bit hold, input logic [7:0] next_d,
                      input int pulse_k, input int drop_k);
    int n = 0;
    data_in  = vecs[vi].data;
    valid_in = 1'b1;
    #1;
    while (!ready_out && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      chk("accept_timeout", 32'(n), 32'd0);
      valid_in = 1'b0;
      return;
    end
    @(posedge clk);
    last_acc_t = $time;
    #1;
    if (hold) data_in = next_d; else valid_in = 1'b0;
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_tx_start", 32'(tx), 32'd0);
    for (int k = 1; k <= BIT*NB + 1; k++) begin
      @(negedge clk);
      if (k == pulse_k) begin data_in = 8'h3C; valid_in = 1'b1; end
      else if (pulse_k > 0 && k == pulse_k + 1) valid_in = 1'b0;
      if (k == drop_k) ena = 1'b0;
      if (k >= BIT/2 + 1 && (k - BIT/2 - 1) % BIT == 0) begin
        chk($sformatf("v%0d_bit%0d", vi, (k - BIT/2 - 1) / BIT), 32'(tx),
            32'(exp_bit(vi, (k - BIT/2 - 1) / BIT)));
        chk("ready_low_in_frame", 32'(ready_out), 32'd0);
      end
      if (k == BIT*NB) chk("busy_last_cycle", 32'(busy), 32'd1);
    end
    chk("busy_fall", 32'(busy), 32'd0);
    chk("tx_idle_gap", 32'(tx), 32'd1);
    chk("ready_after", 32'(ready_out), 32'(ena));
  endtask

  initial begin
    int nb;
    time t0;
    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h81, 10'b0100000011, 1'b0};
    vecs[2] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[3] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[4] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[5] = '{8'hFF, 10'b0111111111, 1'b0};

    // Reset asserted before any clock edge: outputs must settle asynchronously.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) send(i, 1'b0, 8'h00, 0, 0);

    // Back-to-back 0x00 then 0xFF with valid held.
    send(4, 1'b1, 8'hFF, 0, 0);
    t0 = last_acc_t;
    send(5, 1'b0, 8'h00, 0, 0);
    chk("b2b_spacing", 32'(last_acc_t - t0), 32'((BIT*NB + 1) * 10));

    // Valid pulse while busy is dropped and nothing follows.
    send(1, 1'b0, 8'h00, 100, 0);
    nb = 0;
    repeat (50) begin @(negedge clk); if (busy !== 1'b0 || tx !== 1'b1) nb++; end
    chk("pulse_ignored", 32'(nb), 32'd0);

    // ena low blocks acceptance; raise it and the byte goes on the next edge.
    ena = 1'b0; data_in = 8'h3C; valid_in = 1'b1;
    nb = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || ready_out !== 1'b0) nb++;
    end
    chk("ena_block", 32'(nb), 32'd0);
    t0 = $time;
    ena = 1'b1;
    send(2, 1'b0, 8'h00, 0, 150);
    chk("ena_accept_first_edge", 32'(last_acc_t - t0), 32'd5);
    @(negedge clk);
    ena = 1'b1;

    // Reset mid-DATA returns tx high without a clock edge; frame is not resumed.
    data_in = 8'h00; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (BIT*3) @(negedge clk);
    chk("mid_tx_low", 32'(tx), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    repeat (40) begin @(negedge clk); if (busy !== 1'b0 || tx !== 1'b1) nb++; end
    chk("no_resume", 32'(nb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
